// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port valid/ready memory.
// One access at a time: IDLE grants a port, ISSUE waits for ready or watchdog, RESP reports.
module mem_arbiter #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  p0_valid_i,
   input  logic                  p0_wr_rd_i,
   input  logic [ADDR_WIDTH-1:0] p0_addr_i,
   input  logic [WIDTH-1:0]      p0_wdata_i,
   output logic                  p0_done_o,
   output logic                  p0_err_o,
   output logic [WIDTH-1:0]      p0_rdata_o,
   input  logic                  p1_valid_i,
   input  logic                  p1_wr_rd_i,
   input  logic [ADDR_WIDTH-1:0] p1_addr_i,
   input  logic [WIDTH-1:0]      p1_wdata_i,
   output logic                  p1_done_o,
   output logic                  p1_err_o,
   output logic [WIDTH-1:0]      p1_rdata_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_wr_rd_o,
   output logic [WIDTH-1:0]      mem_wdata_o,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   input  logic [WIDTH-1:0]      mem_rdata_i,
   output logic                  busy_o,
   output logic                  grant_o
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic [WD_W-1:0]         wd_q, wd_d;
   logic                    ptr_q, ptr_d;
   logic                    grant_q, grant_d;
   logic                    err_q, err_d;
   logic                    busy_q, busy_d;
   logic                    mem_valid_q, mem_valid_d;
   logic                    mem_wr_rd_q, mem_wr_rd_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]        mem_wdata_q, mem_wdata_d;
   logic [WIDTH-1:0]        rdata0_q, rdata0_d;
   logic [WIDTH-1:0]        rdata1_q, rdata1_d;
   logic [1:0]              done_q, done_d;
   logic [1:0]              perr_q, perr_d;
   logic                    req_any_s;
   logic                    pick_s;
   logic                    expire_s;

   assign req_any_s = p0_valid_i | p1_valid_i;
   assign expire_s  = (wd_q == WD_LAST);

   // Port selection: the pointer only matters when both ports are asking.
   always_comb begin
      pick_s = 1'b0;
      if (p0_valid_i && p1_valid_i) begin
         pick_s = ptr_q;
      end else begin
         pick_s = p1_valid_i;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         wd_q        <= '0;
         ptr_q       <= 1'b0;
         grant_q     <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_wr_rd_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         done_q      <= 2'b00;
         perr_q      <= 2'b00;
      end else begin
         state_q     <= state_d;
         wd_q        <= wd_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         mem_valid_q <= mem_valid_d;
         mem_wr_rd_q <= mem_wr_rd_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         done_q      <= done_d;
         perr_q      <= perr_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_any_s) state_d = ISSUE; else state_d = IDLE;
         ISSUE:   if (mem_ready_i || expire_s) state_d = RESP; else state_d = ISSUE;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; a ready in the expiry cycle counts as success.
   always_comb begin
      wd_d        = wd_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      err_d       = err_q;
      mem_valid_d = mem_valid_q;
      mem_wr_rd_d = mem_wr_rd_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      done_d      = 2'b00;
      perr_d      = 2'b00;
      busy_d      = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (req_any_s) begin
               grant_d     = pick_s;
               mem_valid_d = 1'b1;
               mem_wr_rd_d = pick_s ? p1_wr_rd_i : p0_wr_rd_i;
               mem_addr_d  = pick_s ? p1_addr_i  : p0_addr_i;
               mem_wdata_d = pick_s ? p1_wdata_i : p0_wdata_i;
               wd_d        = '0;
            end else begin
               mem_valid_d = 1'b0;
            end
         end
         ISSUE: begin
            if (mem_ready_i) begin
               mem_valid_d = 1'b0;
               err_d       = 1'b0;
               if (!mem_wr_rd_q && grant_q) begin
                  rdata1_d = mem_rdata_i;
               end else if (!mem_wr_rd_q) begin
                  rdata0_d = mem_rdata_i;
               end else begin
                  rdata0_d = rdata0_q;
               end
            end else if (expire_s) begin
               mem_valid_d = 1'b0;
               err_d       = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         RESP: begin
            done_d = grant_q ? 2'b10 : 2'b01;
            perr_d = grant_q ? {err_q, 1'b0} : {1'b0, err_q};
            ptr_d  = ~grant_q;
         end
         default: begin
            mem_valid_d = 1'b0;
         end
      endcase
   end

   assign p0_done_o   = done_q[0];
   assign p1_done_o   = done_q[1];
   assign p0_err_o    = perr_q[0];
   assign p1_err_o    = perr_q[1];
   assign p0_rdata_o  = rdata0_q;
   assign p1_rdata_o  = rdata1_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wr_rd_o = mem_wr_rd_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_valid_o = mem_valid_q;
   assign busy_o      = busy_q;
   assign grant_o     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: bench-side memory responder, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_mem_arbiter;
   localparam int WIDTH   = 16;
   localparam int AW      = 4;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [1:0]       v, wr;
   logic [AW-1:0]    addr [2];
   logic [WIDTH-1:0] wd [2];
   logic             mem_ready;
   logic [WIDTH-1:0] mem_rdata;
   logic             p0_done, p1_done, p0_err, p1_err;
   logic [WIDTH-1:0] p0_rdata, p1_rdata, mem_wdata;
   logic [AW-1:0]    mem_addr;
   logic             mem_wr_rd, mem_valid, busy, grant;
   logic [1:0]       done, err;
   assign done = {p1_done, p0_done};
   assign err  = {p1_err, p0_err};

   mem_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .p0_valid_i(v[0]), .p0_wr_rd_i(wr[0]), .p0_addr_i(addr[0]), .p0_wdata_i(wd[0]),
      .p0_done_o(p0_done), .p0_err_o(p0_err), .p0_rdata_o(p0_rdata),
      .p1_valid_i(v[1]), .p1_wr_rd_i(wr[1]), .p1_addr_i(addr[1]), .p1_wdata_i(wd[1]),
      .p1_done_o(p1_done), .p1_err_o(p1_err), .p1_rdata_o(p1_rdata),
      .mem_addr_o(mem_addr), .mem_wr_rd_o(mem_wr_rd), .mem_wdata_o(mem_wdata),
      .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
      .busy_o(busy), .grant_o(grant)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // bench memory and responder configuration
   logic [WIDTH-1:0] mem [16];
   logic [WIDTH-1:0] sb [16];
   int  mem_lat  = 2;
   bit  rand_lat = 1'b0;
   bit  allow_to = 1'b0;
   int  mcnt     = 0;
   int  cur_lat  = 0;

   // reference model state
   bit               m_ok = 1'b0, m_active, m_finish, m_favor, m_err;
   int               m_high;
   logic             e_mvalid, e_mwr, e_busy, e_grant;
   logic [AW-1:0]    e_maddr;
   logic [WIDTH-1:0] e_mwd;
   logic [1:0]       e_done, e_err;
   logic [WIDTH-1:0] e_rdata [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_ok = 1'b1; m_active = 1'b0; m_finish = 1'b0; m_favor = 1'b0; m_err = 1'b0; m_high = 0;
         e_mvalid = 1'b0; e_mwr = 1'b0; e_busy = 1'b0; e_grant = 1'b0;
         e_maddr = '0; e_mwd = '0; e_done = 2'b00; e_err = 2'b00;
         e_rdata[0] = '0; e_rdata[1] = '0;
      end else if (m_ok) begin
         e_done = 2'b00;
         e_err  = 2'b00;
         if (m_finish) begin
            e_done[e_grant] = 1'b1;
            e_err[e_grant]  = m_err;
            m_favor  = ~e_grant;
            m_finish = 1'b0;
            e_busy   = 1'b0;
         end else if (m_active) begin
            m_high++;
            if (mem_ready || m_high == TIMEOUT) begin
               m_err = !mem_ready;
               if (mem_ready && !e_mwr) e_rdata[e_grant] = mem_rdata;
               m_active = 1'b0;
               m_finish = 1'b1;
               e_mvalid = 1'b0;
            end
         end else if (v != 2'b00) begin
            e_grant  = (v == 2'b11) ? m_favor : v[1];
            e_mwr    = wr[e_grant];
            e_maddr  = addr[e_grant];
            e_mwd    = wd[e_grant];
            e_mvalid = 1'b1;
            e_busy   = 1'b1;
            m_active = 1'b1;
            m_high   = 0;
         end
      end
   endtask

   task automatic compare_all();
      chk("mem_valid", 32'(mem_valid), 32'(e_mvalid));
      chk("mem_addr",  32'(mem_addr),  32'(e_maddr));
      chk("mem_wr_rd", 32'(mem_wr_rd), 32'(e_mwr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_mwd));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("grant",     32'(grant),     32'(e_grant));
      chk("done",      32'(done),      32'(e_done));
      chk("err",       32'(err),       32'(e_err));
      chk("p0_rdata",  32'(p0_rdata),  32'(e_rdata[0]));
      chk("p1_rdata",  32'(p1_rdata),  32'(e_rdata[1]));
   endtask

   function automatic int pick_lat();
      int r;
      r = $urandom_range(0, 9);
      if (!allow_to || r < 7) return 1 + (r % 4);
      if (r == 7) return 16;
      if (r == 8) return 0;
      return 15;
   endfunction

   task automatic mem_respond();
      if (mem_valid === 1'b1) mcnt++; else mcnt = 0;
      if (mem_valid === 1'b1 && mcnt == 1) cur_lat = rand_lat ? pick_lat() : mem_lat;
      if (mem_valid === 1'b1 && cur_lat != 0 && mcnt == cur_lat) begin
         mem_ready = 1'b1;
         if (mem_wr_rd) begin
            mem[mem_addr] = mem_wdata;
            mem_rdata = WIDTH'($urandom);
         end else begin
            mem_rdata = mem[mem_addr];
         end
      end else begin
         mem_ready = 1'b0;
         mem_rdata = WIDTH'($urandom);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_ok) compare_all();
      mem_respond();
   endtask

   task automatic do_req(input int p, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                         output logic er, output logic [WIDTH-1:0] rd, output int hi,
                         output bit other, output bit fld_ok);
      v[p] = 1'b1; wr[p] = w; addr[p] = a; wd[p] = d;
      er = 1'b0; rd = '0; hi = 0; other = 1'b0; fld_ok = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (mem_valid === 1'b1) begin
            hi++;
            if (mem_addr !== a || mem_wr_rd !== w || (w && mem_wdata !== d)) fld_ok = 1'b0;
         end
         if (done[1-p]) other = 1'b1;
         if (done[p]) begin
            er = err[p];
            rd = (p == 1) ? p1_rdata : p0_rdata;
            v[p] = 1'b0;
            return;
         end
      end
      v[p] = 1'b0;
      n_tests++;
      n_fail++;
      $display("FAIL req_bound: port %0d got no done within 60 cycles, required done", p);
   endtask

   task automatic free_run(input int cycles, input bit allow_new);
      for (int c = 0; c < cycles; c++) begin
         tick();
         for (int p = 0; p < 2; p++) begin
            if (v[p] && done[p]) begin
               if (!allow_new || $urandom_range(0, 3) != 0) v[p] = 1'b0;
            end else if (allow_new && !v[p] && $urandom_range(0, 2) == 0) begin
               v[p]    = 1'b1;
               wr[p]   = 1'($urandom_range(0, 1));
               addr[p] = AW'($urandom);
               wd[p]   = WIDTH'($urandom);
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_time_limit: simulation did not finish, required finish");
      $fatal(1, "time limit");
   end

   initial begin
      logic             er;
      logic [WIDTH-1:0] rd, prev;
      int               hi, nd;
      bit               other, fld_ok;
      int               seq [4];

      rst = 1'b1; v = 2'b00; wr = 2'b00; mem_ready = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 2; i++) begin addr[i] = '0; wd[i] = '0; end
      for (int i = 0; i < 16; i++) mem[i] = '0;

      // reset state
      tick(); tick();
      rst = 1'b0;
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_grant",     32'(grant),     32'd0);
      chk("rst_p0_rdata",  32'(p0_rdata),  32'd0);

      // single write, ready two cycles after mem_valid
      mem_lat = 2;
      do_req(0, 1'b1, 4'd3, 16'hA5A5, er, rd, hi, other, fld_ok);
      chk("wr_err",      32'(er),     32'd0);
      chk("wr_p1_done",  32'(other),  32'd0);
      chk("wr_fields",   32'(fld_ok), 32'd1);
      chk("wr_hi_cycles", 32'(hi),    32'd2);
      tick();
      chk("wr_done_pulse", 32'(p0_done), 32'd0);

      // read back on p1
      do_req(1, 1'b0, 4'd3, 16'h0000, er, rd, hi, other, fld_ok);
      chk("rd_p1_rdata", 32'(rd),       32'hA5A5);
      chk("rd_p0_rdata", 32'(p0_rdata), 32'd0);
      chk("rd_err",      32'(er),       32'd0);

      // contention from reset: grants alternate p0,p1,p0,p1
      rst = 1'b1; tick(); rst = 1'b0;
      v = 2'b11; wr = 2'b00; addr[0] = 4'd5; addr[1] = 4'd9;
      nd = 0;
      for (int i = 0; i < 4; i++) seq[i] = 2;
      for (int i = 0; i < 80 && nd < 4; i++) begin
         tick();
         if (done[0]) begin seq[nd] = 0; nd++; end
         else if (done[1]) begin seq[nd] = 1; nd++; end
      end
      v = 2'b00;
      chk("cont_count", 32'(nd), 32'd4);
      chk("cont_seq0", 32'(seq[0]), 32'd0);
      chk("cont_seq1", 32'(seq[1]), 32'd1);
      chk("cont_seq2", 32'(seq[2]), 32'd0);
      chk("cont_seq3", 32'(seq[3]), 32'd1);
      free_run(10, 1'b0);

      // timeout: memory never ready
      prev = p0_rdata;
      mem_lat = 0;
      do_req(0, 1'b0, 4'd7, 16'h0000, er, rd, hi, other, fld_ok);
      chk("to_hi_cycles", 32'(hi), 32'd16);
      chk("to_err",       32'(er), 32'd1);
      chk("to_rdata",     32'(rd), 32'(prev));
      mem_lat = 2;
      do_req(1, 1'b1, 4'd4, 16'h1234, er, rd, hi, other, fld_ok);
      chk("after_to_err", 32'(er), 32'd0);

      // reset mid-ISSUE, after p0 was last served
      do_req(0, 1'b0, 4'd4, 16'h0000, er, rd, hi, other, fld_ok);
      mem_lat = 0;
      v[1] = 1'b1; wr[1] = 1'b1; addr[1] = 4'd2; wd[1] = 16'h0F0F;
      tick(); tick(); tick();
      chk("mid_valid_before", 32'(mem_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid_after", 32'(mem_valid), 32'd0);
      chk("mid_busy_after",  32'(busy),      32'd0);
      chk("mid_no_done",     32'(done),      32'd0);
      mem_lat = 2;
      v[0] = 1'b1; wr[0] = 1'b0; addr[0] = 4'd3;
      tick();
      chk("mid_first_grant", 32'(grant), 32'd0);
      chk("mid_busy",        32'(busy),  32'd1);
      free_run(30, 1'b0);

      // sweep: p0 writes every address, then p1 reads them back
      rand_lat = 1'b1; allow_to = 1'b0;
      for (int a = 0; a < 16; a++) begin
         sb[a] = WIDTH'($urandom);
         do_req(0, 1'b1, AW'(a), sb[a], er, rd, hi, other, fld_ok);
      end
      for (int a = 0; a < 16; a++) begin
         do_req(1, 1'b0, AW'(a), 16'h0000, er, rd, hi, other, fld_ok);
         chk("sweep_rdata", 32'(rd), 32'(sb[a]));
         chk("sweep_err",   32'(er), 32'd0);
      end

      // random traffic with occasional timeouts and ready-at-expiry
      allow_to = 1'b1;
      free_run(900, 1'b1);
      free_run(120, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port `memory` block (valid/ready, `wr_rd` select). Two independent requesters each issue one read or write at a time. The arbiter grants one requester, drives the memory handshake, and returns write completion or read data to the granted requester. A watchdog aborts any access the memory never acknowledges.

## Interface
- `WIDTH`, 16, data width; matches `memory`
- `DEPTH`, 16, memory words
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width
- `TIMEOUT`, 16, max cycles `mem_valid` stays high without `mem_ready` before abort (>=1)

- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `p0_valid` / `p1_valid` in 1: request pending; held with its fields stable until that port's `done`
- `p0_wr_rd` / `p1_wr_rd` in 1: 1 = write, 0 = read
- `p0_addr` / `p1_addr` in ADDR_WIDTH: word address
- `p0_wdata` / `p1_wdata` in WIDTH: write data
- `p0_done` / `p1_done` out 1: one-cycle completion pulse
- `p0_err` / `p1_err` out 1: high with `done` on timeout abort
- `p0_rdata` / `p1_rdata` out WIDTH: last read data for that port; held between reads
- `mem_addr` out ADDR_WIDTH: address to `memory`
- `mem_wr_rd` out 1: direction to `memory`
- `mem_wdata` out WIDTH: write data to `memory`
- `mem_valid` out 1: access request to `memory`
- `mem_ready` in 1: access accepted/completed by `memory`
- `mem_rdata` in WIDTH: read data; valid in the cycle `mem_ready`=1 for a read
- `busy` out 1: state != IDLE
- `grant` out 1: port currently or last granted

## Operation
- FSM: IDLE -> ISSUE -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - If any `pN_valid`=1, select a port and latch its `wr_rd`/`addr`/`wdata` into `mem_*`.
  - Set `grant`, `mem_valid`=1, clear the watchdog, and go to ISSUE.
- Priority:
  - The round-robin pointer favours the port not last served. After reset it favours p0.
  - With only one port valid, that port wins regardless of the pointer.
- ISSUE: `mem_*` stay stable while `mem_valid`=1.
  - If `mem_ready`=1 at an edge: drop `mem_valid`; on a read, capture `mem_rdata` into `p<grant>_rdata`; go to RESP with err=0.
  - Else if the watchdog reaches TIMEOUT-1: drop `mem_valid`; go to RESP with err=1. `rdata` is unchanged.
  - Else increment the watchdog, which is `$clog2(TIMEOUT+1)` bits wide.
  - If `mem_ready` and the timeout limit occur in the same cycle, success wins.
- RESP:
  - Pulse `p<grant>_done`=1 and `p<grant>_err` for one cycle. The other port's `done`/`err` stay 0.
  - Point the round-robin pointer at the other port, then return to IDLE.
- Requester rule:
  - A requester samples `done` and may drop or change `valid` at the following edge.
  - If `valid` is still high in the IDLE cycle after RESP, it is treated as a new request.
- A non-granted port's `valid` only waits. Its fields are not sampled.
- `addr` is passed through unchanged. There is no wrap or range check; every ADDR_WIDTH value is legal.

## Timing
- Reset (`rst`=1 at an edge):
  - Next cycle: state IDLE, `mem_valid`=0, `mem_addr`/`mem_wdata`/`mem_wr_rd`=0.
  - `p*_done`=0, `p*_err`=0, `p*_rdata`=0, `busy`=0, `grant`=0; pointer favours p0.
- Reset mid-ISSUE or mid-RESP: the transaction is dropped. No `done` pulse is issued and `mem_valid` is low the next cycle.
- Latency:
  - Request seen at edge k -> `mem_valid` high after edge k.
  - `mem_ready` sampled at edge k+n (n>=1) -> `done` high after edge k+n+1, low after k+n+2.
  - Minimum request-to-done is 2 edges. Minimum back-to-back period is 3 cycles per access.
- Timeout: with `mem_ready` stuck at 0, `mem_valid` is high for exactly TIMEOUT cycles, then `done`+`err` assert the next cycle.
- `mem_valid` never rises in the cycle after it falls.

## Test plan
- Single write, memory ready 2 cycles after `mem_valid`: p0 writes addr 3, data 16'hA5A5.
  - `mem_addr`=3, `mem_wdata`=16'hA5A5, `mem_wr_rd`=1 held until ready.
  - `p0_done` is a 1-cycle pulse with `p0_err`=0; `p1_done` stays 0.
- Read-back: p1 reads addr 3 -> `p1_rdata`=16'hA5A5 when `p1_done` pulses. `p0_rdata` is unchanged.
- Contention: both ports hold `valid` continuously after reset -> grants go p0, p1, p0, p1 over 4 accesses; `done` pulses alternate.
- Timeout: tie `mem_ready`=0, p0 reads addr 7.
  - `mem_valid` is high for exactly 16 cycles, then `p0_done`=`p0_err`=1 for one cycle and `p0_rdata` is unchanged.
  - A following p1 write with a normal memory completes with `err`=0.
- Reset mid-ISSUE: assert `rst` for 1 cycle while `mem_valid`=1.
  - `mem_valid`=0 and `busy`=0 the next cycle; no `done` pulse.
  - With both ports then valid, p0 is granted first.
- Sweep with the real `memory`: p0 writes `$random` data to addrs 0..15 while p1 reads 0..15 interleaved afterward -> every p1 read matches the scoreboard, including addr 15.
